axis_tx_frame_arbiter: RTL and testbench

- Shares the single 24-bit AXI-Stream transmit port of the I2S2 codec interface between several stereo sample sources, e.g. tone generator, line-in loopback and effects path.
- Grants one source per stereo frame (L beat, then R beat with last=1); switches only at frame boundaries, so channels never swap or tear.
- Registered output stage; sits between the sample producers and the codec's tx AXIS port, in the codec clock domain.

---
 rtl/axis_tx_frame_arbiter.sv | 175 +++++++++++++++++
 tb/tb_axis_tx_frame_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tx_frame_arbiter.sv
// Frame-granular arbiter feeding the codec's AXIS tx port from several stereo sources.
// Optional zero-sample fill while idle: define AXIS_TX_FRAME_ARBITER_SILENCE_FILL_EN.
//
// state | meaning
// IDLE  | arbitrate among valid, unmasked sources (one bubble cycle)
// LEFT  | forward L beat of granted source
// RIGHT | forward R beat, force last, release grant
// SIL_L | silence fill, zero L beat
// SIL_R | silence fill, zero R beat with last
module axis_tx_frame_arbiter #(
  parameter int width_p   = 24,
  parameter int num_src_p = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           mode_i,
  input  logic [num_src_p-1:0]           src_mask_i,
  input  logic [num_src_p*width_p-1:0]   src_data_i,
  input  logic [num_src_p-1:0]           src_valid_i,
  input  logic [num_src_p-1:0]           src_last_i,
  output logic [num_src_p-1:0]           src_ready_o,
  output logic [width_p-1:0]             tx_data_o,
  output logic                           tx_valid_o,
  output logic                           tx_last_o,
  input  logic                           tx_ready_i,
  output logic [num_src_p-1:0]           grant_o,
  output logic                           err_o
);

  localparam int ptr_w_lp = $clog2(num_src_p);

  typedef enum logic [2:0] {IDLE, LEFT, RIGHT, SIL_L, SIL_R} state_e;

  state_e                 state_q, state_d;
  logic [num_src_p-1:0]   grant_q, grant_d;
  logic [ptr_w_lp-1:0]    ptr_q, ptr_d;
  logic [width_p-1:0]     data_q, load_data;
  logic                   valid_q, last_q, err_q, err_d;
  logic                   load, load_last;
  logic                   out_free, busy, accept;
  logic [width_p-1:0]     sel_data;
  logic                   sel_valid, sel_last;
  logic [num_src_p-1:0]   cand, win_onehot;
  logic [ptr_w_lp-1:0]    win_idx;

  assign out_free    = ~valid_q | tx_ready_i;
  assign busy        = (state_q == LEFT) || (state_q == RIGHT);
  assign accept      = busy & out_free & sel_valid;
  assign src_ready_o = grant_q & {num_src_p{busy & out_free}};

  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;
  assign tx_last_o  = last_q;
  assign grant_o    = grant_q;
  assign err_o      = err_q;

  // grant_q is one-hot or zero, so an OR-mux selects the owner
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < num_src_p; i++) begin
      if (grant_q[i]) begin
        sel_data  = sel_data | src_data_i[i*width_p +: width_p];
        sel_valid = sel_valid | src_valid_i[i];
        sel_last  = sel_last | src_last_i[i];
      end
    end
  end

  // Scan downward so the last hit is the lowest index / nearest after the pointer
  always_comb begin
    cand    = src_valid_i & src_mask_i;
    win_idx = '0;
    if (mode_i) begin
      for (int k = num_src_p; k >= 1; k--) begin
        if (cand[(int'(ptr_q) + k) % num_src_p])
          win_idx = ptr_w_lp'((int'(ptr_q) + k) % num_src_p);
      end
    end else begin
      for (int i = num_src_p - 1; i >= 0; i--) begin
        if (cand[i]) win_idx = ptr_w_lp'(i);
      end
    end
    win_onehot = num_src_p'(1) << win_idx;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    load      = 1'b0;
    load_data = sel_data;
    load_last = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          grant_d = win_onehot;
          ptr_d   = win_idx;
          state_d = LEFT;
        end
`ifdef AXIS_TX_FRAME_ARBITER_SILENCE_FILL_EN
        else if (out_free) begin
          state_d = SIL_L;
        end
`endif
      end
      LEFT: begin
        if (accept) begin
          load = 1'b1;
          // a premature last resyncs: the next beat is taken as L again
          if (sel_last) err_d = 1'b1;
          else          state_d = RIGHT;
        end
      end
      RIGHT: begin
        if (accept) begin
          load      = 1'b1;
          load_last = 1'b1;
          err_d     = ~sel_last;
          grant_d   = '0;
          state_d   = IDLE;
        end
      end
`ifdef AXIS_TX_FRAME_ARBITER_SILENCE_FILL_EN
      SIL_L: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = '0;
          state_d   = SIL_R;
        end
      end
      SIL_R: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = '0;
          load_last = 1'b1;
          state_d   = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= ptr_w_lp'(num_src_p - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      last_q  <= load_last;
    end else if (tx_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_tx_frame_arbiter.sv
// Directed bench for axis_tx_frame_arbiter: priority, round-robin, backpressure,
// framing error, mask/reset and idle behaviour, against hand-computed beat lists.
module tb_axis_tx_frame_arbiter;

  localparam int W = 24;
  localparam int N = 2;

  logic           clk_i = 1'b0;
  logic           reset_n_i, mode_i, tx_ready_i;
  logic [N-1:0]   src_mask_i, src_valid_i, src_last_i, src_ready_o, grant_o;
  logic [N*W-1:0] src_data_i;
  logic [W-1:0]   tx_data_o;
  logic           tx_valid_o, tx_last_o, err_o;

  always #5 clk_i = ~clk_i;

  axis_tx_frame_arbiter #(.width_p(W), .num_src_p(N)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .mode_i      (mode_i),
    .src_mask_i  (src_mask_i),
    .src_data_i  (src_data_i),
    .src_valid_i (src_valid_i),
    .src_last_i  (src_last_i),
    .src_ready_o (src_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_last_o   (tx_last_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .err_o       (err_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] bd [N][4];
  logic         bl [N][4];
  int           blen [N];
  int           lim [N];
  int           idx [N];
  int           sent [N];
  logic         en [N];

  logic [W:0]   cap_q [$];
  logic [W:0]   exp_q [$];
  int           err_cnt, val_cnt, bad_grant;
  logic [N-1:0] grant_ok;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && sent[i] < lim[i]) begin
        src_valid_i[i]         = 1'b1;
        src_data_i[i*W +: W]   = bd[i][idx[i]];
        src_last_i[i]          = bl[i][idx[i]];
      end else begin
        src_valid_i[i]         = 1'b0;
        src_data_i[i*W +: W]   = '0;
        src_last_i[i]          = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] fire;
    drive_srcs();
    #1;
    fire = src_valid_i & src_ready_o;
    if (tx_valid_o && tx_ready_i) cap_q.push_back({tx_last_o, tx_data_o});
    if (err_o) err_cnt++;
    if (tx_valid_o) val_cnt++;
    if (grant_o != '0 && grant_o != grant_ok) bad_grant++;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        idx[i] = (idx[i] + 1) % blen[i];
        sent[i]++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    reset_n_i   = 1'b0;
    src_valid_i = '0;
    src_data_i  = '0;
    src_last_i  = '0;
    for (int i = 0; i < N; i++) begin
      idx[i]  = 0;
      sent[i] = 0;
    end
    cap_q.delete();
    err_cnt   = 0;
    val_cnt   = 0;
    bad_grant = 0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic setup_std();
    bd[0][0] = 24'h000111; bl[0][0] = 1'b0;
    bd[0][1] = 24'h000222; bl[0][1] = 1'b1;
    bd[1][0] = 24'h00AAAA; bl[1][0] = 1'b0;
    bd[1][1] = 24'h00BBBB; bl[1][1] = 1'b1;
    blen[0] = 2; blen[1] = 2;
    lim[0] = 1000; lim[1] = 1000;
  endtask

  task automatic expect_beat(input logic l, input logic [W-1:0] d);
    exp_q.push_back({l, d});
  endtask

  task automatic check_caps(input string tag);
    chk($sformatf("%s_count", tag), 32'(cap_q.size() >= exp_q.size()), 32'd1);
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("%s_beat%0d", tag, k),
          32'((k < cap_q.size()) ? cap_q[k] : 25'h1ffffff), 32'(exp_q[k]));
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(tx_valid_o), 32'd0);
    chk({tag, "_data"},  32'(tx_data_o),  32'd0);
    chk({tag, "_last"},  32'(tx_last_o),  32'd0);
    chk({tag, "_ready"}, 32'(src_ready_o), 32'd0);
    chk({tag, "_grant"}, 32'(grant_o),    32'd0);
    chk({tag, "_err"},   32'(err_o),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n_i   = 1'b0;
    mode_i      = 1'b0;
    src_mask_i  = '0;
    tx_ready_i  = 1'b1;
    src_valid_i = '0;
    src_data_i  = '0;
    src_last_i  = '0;
    grant_ok    = '0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; idx[i] = 0; sent[i] = 0;
    end
    setup_std();
    #1;
    chk_outputs_zero("reset");
    do_reset();

    // fixed priority: src0 always wins
    mode_i = 1'b0; src_mask_i = 2'b11; en[0] = 1'b1; en[1] = 1'b1; grant_ok = 2'b01;
    cycle();
    chk("t1_grant_after_arb", 32'(grant_o), 32'h1);
    chk("t1_bubble", 32'(tx_valid_o), 32'd0);
    cycle();
    chk("t1_latency_valid", 32'(tx_valid_o), 32'd1);
    chk("t1_latency_data", 32'(tx_data_o), 32'h000111);
    run(11);
    for (int f = 0; f < 4; f++) begin
      expect_beat(1'b0, 24'h000111);
      expect_beat(1'b1, 24'h000222);
    end
    check_caps("t1");
    chk("t1_grant_only_src0", 32'(bad_grant), 32'd0);

    // round-robin alternation
    do_reset();
    mode_i = 1'b1; grant_ok = 2'b11;
    run(14);
    for (int f = 0; f < 2; f++) begin
      expect_beat(1'b0, 24'h000111);
      expect_beat(1'b1, 24'h000222);
      expect_beat(1'b0, 24'h00AAAA);
      expect_beat(1'b1, 24'h00BBBB);
    end
    check_caps("t2");
    chk("t2_no_err", 32'(err_cnt), 32'd0);

    // backpressure mid-frame
    do_reset();
    mode_i = 1'b0; src_mask_i = 2'b01; en[1] = 1'b0;
    cycle();
    cycle();
    tx_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      chk($sformatf("t3_hold_valid%0d", s), 32'(tx_valid_o), 32'd1);
      chk($sformatf("t3_hold_data%0d", s),  32'(tx_data_o),  32'h000111);
      chk($sformatf("t3_hold_last%0d", s),  32'(tx_last_o),  32'd0);
      chk($sformatf("t3_src_ready%0d", s),  32'(src_ready_o), 32'd0);
    end
    tx_ready_i = 1'b1;
    run(8);
    expect_beat(1'b0, 24'h000111);
    expect_beat(1'b1, 24'h000222);
    expect_beat(1'b0, 24'h000111);
    expect_beat(1'b1, 24'h000222);
    check_caps("t3");

    // framing error: premature last on the L beat
    do_reset();
    bd[0][0] = 24'h000111; bl[0][0] = 1'b1;
    bd[0][1] = 24'h000333; bl[0][1] = 1'b0;
    bd[0][2] = 24'h000444; bl[0][2] = 1'b1;
    blen[0] = 3; lim[0] = 3;
    run(8);
    expect_beat(1'b0, 24'h000111);
    expect_beat(1'b0, 24'h000333);
    expect_beat(1'b1, 24'h000444);
    check_caps("t4");
    chk("t4_err_pulses", 32'(err_cnt), 32'd1);
    setup_std();

    // mask change mid-frame, then reset while in LEFT
    do_reset();
    mode_i = 1'b0; src_mask_i = 2'b11; en[0] = 1'b1; en[1] = 1'b1;
    cycle();
    cycle();
    src_mask_i = 2'b10;
    run(8);
    expect_beat(1'b0, 24'h000111);
    expect_beat(1'b1, 24'h000222);
    expect_beat(1'b0, 24'h00AAAA);
    expect_beat(1'b1, 24'h00BBBB);
    check_caps("t5");
    chk("t5_grant_src1", 32'(grant_o), 32'h2);
    drive_srcs();
    #1;
    reset_n_i = 1'b0;
    #1;
    chk_outputs_zero("t5_midreset");
    src_mask_i = 2'b11;
    do_reset();
    cycle();
    chk("t5_fresh_grant", 32'(grant_o), 32'h1);
    run(4);
    expect_beat(1'b0, 24'h000111);
    expect_beat(1'b1, 24'h000222);
    check_caps("t5_post");

    // no sources valid
    do_reset();
    en[0] = 1'b0; en[1] = 1'b0; grant_ok = '0;
    run(12);
`ifdef AXIS_TX_FRAME_ARBITER_SILENCE_FILL_EN
    for (int f = 0; f < 2; f++) begin
      expect_beat(1'b0, 24'h000000);
      expect_beat(1'b1, 24'h000000);
    end
    check_caps("t6_silence");
    chk("t6_grant_zero", 32'(bad_grant), 32'd0);
`else
    chk("t6_no_valid", 32'(val_cnt), 32'd0);
    chk("t6_grant_zero", 32'(bad_grant), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
